mips_exec_mem_stage: RTL and testbench

- Single-cycle MIPS execute/memory slice combining three functions:
  - main and ALU decoder (controller);
  - 32-bit ALU with internal ALUSrc operand mux;
  - word-addressed data RAM.
- Sits between the register file / sign extender and the write-back mux (result = read_data when mem_to_reg, else alu_result) of the processor top.
- Also drives PC-select and register-file control.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/mips_exec_mem_stage_if.sv | 33 +++
 rtl/mips_alu.sv | 32 +++
 rtl/mips_exec_mem_stage.sv | 106 ++++++++++
 tb/tb_mips_exec_mem_stage.sv | 136 +++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared opcode, funct and ALU-control encodings for the MIPS execute/memory slice.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_exec_mem_stage_if.sv
// Instruction fields, operands and decoded controls/results of the execute/memory slice.
interface mips_exec_mem_stage_if #(
    parameter int DATA_W = 32
);
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] sign_imm;
    logic              mem_to_reg;
    logic              mem_write;
    logic              pc_src;
    logic              alu_src;
    logic              reg_dst;
    logic              reg_write;
    logic              jump;
    logic [2:0]        alu_control;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [DATA_W-1:0] read_data;

    modport master (
        output opcode, funct, rd1, rd2, sign_imm,
        input  mem_to_reg, mem_write, pc_src, alu_src, reg_dst, reg_write, jump,
        input  alu_control, alu_result, zero, read_data
    );

    modport slave (
        input  opcode, funct, rd1, rd2, sign_imm,
        output mem_to_reg, mem_write, pc_src, alu_src, reg_dst, reg_write, jump,
        output alu_control, alu_result, zero, read_data
    );
endinterface

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU with zero flag; unused control codes yield 0.
module mips_alu
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [2:0]        i_alu_control,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    logic w_lt;

    assign w_lt = ($signed(i_a) < $signed(i_b));

    always_comb begin
        o_result = '0;
        case (i_alu_control)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_SLT: o_result = {{(DATA_W-1){1'b0}}, w_lt};
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/mips_exec_mem_stage.sv
// Single-cycle MIPS execute/memory slice: main+ALU decoder, ALU, word-addressed data RAM.
module mips_exec_mem_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  clr,
    mips_exec_mem_stage_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              w_mem_to_reg;
    logic              w_mem_write;
    logic              w_branch;
    logic              w_alu_src;
    logic              w_reg_dst;
    logic              w_reg_write;
    logic              w_jump;
    logic [2:0]        w_alu_control;
    logic [DATA_W-1:0] w_src_b;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_zero;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_comb begin
        w_mem_to_reg  = 1'b0;
        w_mem_write   = 1'b0;
        w_branch      = 1'b0;
        w_alu_src     = 1'b0;
        w_reg_dst     = 1'b0;
        w_reg_write   = 1'b0;
        w_jump        = 1'b0;
        w_alu_control = ALU_ADD;
        case (bus.opcode)
            OP_RTYPE: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
                case (bus.funct)
                    F_ADD:   w_alu_control = ALU_ADD;
                    F_SUB:   w_alu_control = ALU_SUB;
                    F_AND:   w_alu_control = ALU_AND;
                    F_OR:    w_alu_control = ALU_OR;
                    F_SLT:   w_alu_control = ALU_SLT;
                    // unknown funct must not corrupt the register file
                    default: w_reg_write   = 1'b0;
                endcase
            end
            OP_LW: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            OP_SW: begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            OP_BEQ: begin
                w_branch      = 1'b1;
                w_alu_control = ALU_SUB;
            end
            OP_ADDI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            OP_J:    w_jump = 1'b1;
            default: ;
        endcase
    end

    assign w_src_b = w_alu_src ? bus.sign_imm : bus.rd2;

    mips_alu #(.DATA_W(DATA_W)) u_alu (
        .i_a           (bus.rd1),
        .i_b           (w_src_b),
        .i_alu_control (w_alu_control),
        .o_result      (w_alu_result),
        .o_zero        (w_zero)
    );

    assign w_addr = w_alu_result[ADDR_W-1:0];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_mem_write) begin
            r_mem[w_addr] <= bus.rd2;
        end
    end

    assign bus.mem_to_reg  = w_mem_to_reg;
    assign bus.mem_write   = w_mem_write;
    assign bus.pc_src      = w_branch & w_zero;
    assign bus.alu_src     = w_alu_src;
    assign bus.reg_dst     = w_reg_dst;
    assign bus.reg_write   = w_reg_write;
    assign bus.jump        = w_jump;
    assign bus.alu_control = w_alu_control;
    assign bus.alu_result  = w_alu_result;
    assign bus.zero        = w_zero;
    assign bus.read_data   = r_mem[w_addr];

endmodule

// File: tb/tb_mips_exec_mem_stage.sv
// Directed-vector bench for mips_exec_mem_stage with hand-computed expectations.
module tb_mips_exec_mem_stage;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    mips_exec_mem_stage_if #(.DATA_W(32)) bus ();

    mips_exec_mem_stage #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // {mem_to_reg, mem_write, pc_src, alu_src, reg_dst, reg_write, jump}
    function automatic logic [31:0] ctl();
        return {25'd0, bus.mem_to_reg, bus.mem_write, bus.pc_src, bus.alu_src,
                bus.reg_dst, bus.reg_write, bus.jump};
    endfunction

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        @(negedge clk);
        bus.opcode   = op;
        bus.funct    = fn;
        bus.rd1      = a;
        bus.rd2      = b;
        bus.sign_imm = imm;
        #1;
    endtask

    initial begin
        bus.opcode = 6'h3f; bus.funct = 6'h00;
        bus.rd1 = '0; bus.rd2 = '0; bus.sign_imm = '0;
        #17 clr = 1'b0;

        // lw after reset reads zero
        drive(6'b100011, 6'd0, 32'd5, 32'd0, 32'd0);
        chk("lw_rdata_reset", bus.read_data, 32'h0);
        chk("lw_ctl", ctl(), 32'b1001010);
        chk("lw_result", bus.alu_result, 32'd5);
        chk("lw_aluctl", bus.alu_control, 32'd2);

        // sw then lw at address 7, read-during-write shows old word first
        drive(6'b101011, 6'd0, 32'd3, 32'hDEADBEEF, 32'd4);
        chk("sw_ctl", ctl(), 32'b0101000);
        chk("sw_result", bus.alu_result, 32'd7);
        chk("sw_old_word", bus.read_data, 32'h0);
        @(posedge clk); #1;
        chk("sw_new_word", bus.read_data, 32'hDEADBEEF);
        drive(6'b100011, 6'd0, 32'd3, 32'd0, 32'd4);
        chk("lw_after_sw", bus.read_data, 32'hDEADBEEF);
        chk("lw_after_sw_addr", bus.alu_result, 32'd7);

        // R-type slt / sub / and / or / unknown funct
        drive(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'd99);
        chk("slt_result", bus.alu_result, 32'd1);
        chk("slt_aluctl", bus.alu_control, 32'd7);
        chk("slt_ctl", ctl(), 32'b0000110);
        drive(6'b000000, 6'b101010, 32'd1, 32'hFFFFFFFF, 32'd0);
        chk("slt_false", bus.alu_result, 32'd0);
        drive(6'b000000, 6'b100010, 32'd9, 32'd9, 32'd5);
        chk("sub_result", bus.alu_result, 32'd0);
        chk("sub_zero", bus.zero, 32'd1);
        chk("sub_aluctl", bus.alu_control, 32'd6);
        drive(6'b000000, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 32'd0);
        chk("and_result", bus.alu_result, 32'h0000F000);
        chk("and_zero", bus.zero, 32'd0);
        drive(6'b000000, 6'b100101, 32'h0000F0F0, 32'h0000FF00, 32'd0);
        chk("or_result", bus.alu_result, 32'h0000FFF0);
        drive(6'b000000, 6'b100000, 32'hFFFFFFFF, 32'd2, 32'd0);
        chk("add_wrap", bus.alu_result, 32'd1);
        drive(6'b000000, 6'b000111, 32'd4, 32'd6, 32'd0);
        chk("badfn_aluctl", bus.alu_control, 32'd2);
        chk("badfn_regwrite", bus.reg_write, 32'd0);
        chk("badfn_result", bus.alu_result, 32'd10);

        // beq taken / not taken
        drive(6'b000100, 6'd0, 32'd12, 32'd12, 32'd100);
        chk("beq_taken_ctl", ctl(), 32'b0010000);
        chk("beq_aluctl", bus.alu_control, 32'd6);
        drive(6'b000100, 6'd0, 32'd12, 32'd13, 32'd100);
        chk("beq_not_taken_ctl", ctl(), 32'b0000000);

        // addi overflow wraps, j, illegal opcode
        drive(6'b001000, 6'd0, 32'h7FFFFFFF, 32'd0, 32'd1);
        chk("addi_result", bus.alu_result, 32'h80000000);
        chk("addi_ctl", ctl(), 32'b0001010);
        drive(6'b000010, 6'b101010, 32'd1, 32'd2, 32'd3);
        chk("j_ctl", ctl(), 32'b0000001);
        drive(6'b111111, 6'b100010, 32'd1, 32'd2, 32'd3);
        chk("illegal_ctl", ctl(), 32'b0000000);
        chk("illegal_aluctl", bus.alu_control, 32'd2);

        // address wrap: 64+2 lands in word 2
        drive(6'b101011, 6'd0, 32'd64, 32'h00000055, 32'd2);
        chk("wrap_result", bus.alu_result, 32'd66);
        @(posedge clk); #1;
        drive(6'b100011, 6'd0, 32'd2, 32'd0, 32'd0);
        chk("wrap_read", bus.read_data, 32'h00000055);
        drive(6'b100011, 6'd0, 32'd0, 32'd0, 32'd7);
        chk("other_word_kept", bus.read_data, 32'hDEADBEEF);
        drive(6'b100011, 6'd0, 32'd2, 32'd0, 32'd0);

        // asynchronous clear mid-cycle
        #2 clr = 1'b1;
        #1;
        chk("clr_async_read", bus.read_data, 32'h0);
        chk("clr_ctl_unaffected", ctl(), 32'b1001010);

        // writes suppressed while clr is high
        drive(6'b101011, 6'd0, 32'd2, 32'h12345678, 32'd0);
        @(posedge clk); #1;
        chk("clr_write_blocked", bus.read_data, 32'h0);
        @(negedge clk);
        clr = 1'b0;
        drive(6'b100011, 6'd0, 32'd7, 32'd0, 32'd0);
        chk("after_clr_read", bus.read_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
